// File: rtl/mode_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mode_dispatch_pkg
// Description : Shared mode encodings, FSM state type and byte-swap helper
//               for the mode_dispatch return-path router.
// Revision    : 1.0 - initial release
// ============================================================================
package mode_dispatch_pkg;

    localparam logic [1:0] MODE_SSD_SWAP = 2'd0;
    localparam logic [1:0] MODE_CH2      = 2'd1;
    localparam logic [1:0] MODE_CH3      = 2'd2;
    localparam logic [1:0] MODE_DROP     = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [15:0] byte_swap(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_fifo
// Description : Small synchronous FIFO (power-of-two depth) with occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_fifo #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DW-1:0]                 wdata,
    output logic [DW-1:0]                 rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int c_aw = $clog2(FIFO_DEPTH);

    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage is not reset; the read side is only trusted while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_level == (c_aw+1)'(FIFO_DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/mode_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : mode_dispatch
// Description : Routes one word stream to three sinks (or discards), with the
//               route frozen for a whole burst and a small output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_dispatch
    import mode_dispatch_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          en_in,
    input  logic [DW-1:0] din,
    output logic          in_ready,
    output logic          en1,
    output logic [DW-1:0] dout1,
    input  logic          rdy1,
    output logic          en2,
    output logic [DW-1:0] dout2,
    input  logic          rdy2,
    output logic          en3,
    output logic [DW-1:0] dout3,
    input  logic          rdy3,
    output logic [1:0]    mode_act,
    output logic          busy,
    output logic          ovf
);

    localparam int           c_cw   = $clog2(BURST_LEN + 1);
    localparam int           c_aw   = $clog2(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(BURST_LEN - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_cw-1:0] r_count;
    logic [1:0]      r_mode_act;
    logic            r_ovf;

    logic [1:0]      w_eff_mode;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [DW-1:0]   w_wdata;
    logic [DW-1:0]   w_rdata;
    logic            w_full;
    logic            w_empty;
    logic [c_aw:0]   w_level;

    assign w_eff_mode = (r_state == IDLE) ? mode : r_mode_act;
    assign in_ready   = (r_state != DRAIN) && !w_full;
    assign w_accept   = en_in && in_ready;
    assign w_push     = w_accept && (w_eff_mode != MODE_DROP);
    assign w_wdata    = (w_eff_mode == MODE_SSD_SWAP) ? byte_swap(din) : din;

    dispatch_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign en1   = !w_empty && (r_mode_act == MODE_SSD_SWAP);
    assign en2   = !w_empty && (r_mode_act == MODE_CH2);
    assign en3   = !w_empty && (r_mode_act == MODE_CH3);
    assign dout1 = en1 ? w_rdata : '0;
    assign dout2 = en2 ? w_rdata : '0;
    assign dout3 = en3 ? w_rdata : '0;
    assign w_pop = (en1 && rdy1) || (en2 && rdy2) || (en3 && rdy3);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (BURST_LEN == 1) ? DRAIN : RUN;
            RUN:     if (w_accept && (r_count == c_last)) w_state_nxt = DRAIN;
            // Leave as soon as the final pop is under way, not a cycle later.
            DRAIN:   if (w_empty || ((w_level == (c_aw+1)'(1)) && w_pop)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_mode_act <= MODE_SSD_SWAP;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == DRAIN) && (w_state_nxt == IDLE)) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
            end
            if (w_accept && (r_state == IDLE)) r_mode_act <= mode;
            if (en_in && !in_ready)            r_ovf      <= 1'b1;
        end
    end

    assign mode_act = r_mode_act;
    assign busy     = (r_state != IDLE);
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mode_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_dispatch
// Description : Directed self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_dispatch;

    localparam int DW = 16, DEPTH = 4, BL = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        en_in = 1'b0;
    logic [15:0] din = '0;
    logic        rdy1 = 1'b0, rdy2 = 1'b0, rdy3 = 1'b0;
    logic        in_ready, en1, en2, en3, busy, ovf;
    logic [15:0] dout1, dout2, dout3;
    logic [1:0]  mode_act;

    mode_dispatch #(.DW(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .mode(mode), .en_in(en_in), .din(din),
        .in_ready(in_ready),
        .en1(en1), .dout1(dout1), .rdy1(rdy1),
        .en2(en2), .dout2(dout2), .rdy2(rdy2),
        .en3(en3), .dout3(dout3), .rdy3(rdy3),
        .mode_act(mode_act), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a burst is "words accepted so far"; at BL it is draining.
    logic [15:0] q[$];
    int          acc  = 0;
    int          mact = 0;
    bit          movf = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            acc  = 0;
            mact = 0;
            movf = 1'b0;
        end else begin
            bit ready, pop, done;
            ready = (acc < BL) && (q.size() < DEPTH);
            pop   = (q.size() > 0) && ((mact == 0 && rdy1) || (mact == 1 && rdy2) || (mact == 2 && rdy3));
            done  = (acc == BL) && ((q.size() - int'(pop)) == 0);
            if (pop) void'(q.pop_front());
            if (en_in && ready) begin
                if (acc == 0) mact = int'(mode);
                if (mact == 0)      q.push_back({din[7:0], din[15:8]});
                else if (mact != 3) q.push_back(din);
                acc++;
            end else if (en_in) begin
                movf = 1'b1;
            end
            if (done) acc = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [15:0] h;
            logic        e1, e2, e3;
            h  = (q.size() > 0) ? q[0] : 16'h0;
            e1 = (q.size() > 0) && (mact == 0);
            e2 = (q.size() > 0) && (mact == 1);
            e3 = (q.size() > 0) && (mact == 2);
            chk("in_ready", in_ready, (acc < BL) && (q.size() < DEPTH));
            chk("en1", en1, e1);
            chk("en2", en2, e2);
            chk("en3", en3, e3);
            chk("dout1", dout1, e1 ? h : 16'h0);
            chk("dout2", dout2, e2 ? h : 16'h0);
            chk("dout3", dout3, e3 ? h : 16'h0);
            chk("mode_act", mode_act, mact[1:0]);
            chk("busy", busy, acc > 0);
            chk("ovf", ovf, movf);
        end
    end

    int popped2 = 0;
    always @(posedge clk) if (!rst && en2 && rdy2) popped2++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [15:0] d);
        mode  = m;
        en_in = 1'b1;
        din   = d;
        cyc();
        en_in = 1'b0;
    endtask

    task automatic do_reset();
        en_in = 1'b0;
        rdy1  = 1'b0;
        rdy2  = 1'b0;
        rdy3  = 1'b0;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Mode 0: byte swap on sink 1
        rdy1 = 1'b1;
        send(2'd0, 16'h1234);
        chk("t1_en1", en1, 1);
        chk("t1_dout1", dout1, 16'h3412);
        chk("t1_dout2", dout2, 0);
        repeat (3) cyc();

        // Mode 1 backpressure and overflow
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send(2'd1, 16'(i));
            if (i == 4) chk("t2_in_ready_low", in_ready, 0);
        end
        chk("t2_ovf", ovf, 1);
        chk("t2_head", dout2, 16'h0001);
        rdy2 = 1'b1;
        repeat (6) cyc();
        chk("t2_idle", busy, 0);

        // Mode change inside a burst is deferred
        do_reset();
        rdy2 = 1'b1;
        rdy3 = 1'b1;
        send(2'd1, 16'hA001);
        send(2'd1, 16'hA002);
        send(2'd2, 16'hA003);
        send(2'd2, 16'hA004);
        chk("t3_busy_drain", busy, 1);
        chk("t3_dout2", dout2, 16'hA004);
        repeat (2) cyc();
        send(2'd2, 16'hA005);
        chk("t3_mode_act", mode_act, 2);
        chk("t3_dout3", dout3, 16'hA005);
        repeat (5) cyc();

        // Discard mode: one-cycle DRAIN
        do_reset();
        for (int i = 0; i < 4; i++) send(2'd3, 16'(i));
        chk("t4_drain_busy", busy, 1);
        chk("t4_drain_ready", in_ready, 0);
        cyc();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_ready", in_ready, 1);

        // Reset mid-burst
        do_reset();
        send(2'd2, 16'hABCD);
        send(2'd2, 16'h00FF);
        chk("t5_en3_before", en3, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_en3_after", en3, 0);
        chk("t5_ready_after", in_ready, 1);
        send(2'd0, 16'hBEEF);
        chk("t5_dout1", dout1, 16'hEFBE);

        // Continuous traffic with toggling backpressure
        do_reset();
        popped2 = 0;
        sent = 0;
        mode = 2'd1;
        for (int c = 0; c < 60; c++) begin
            rdy2  = c[0];
            en_in = in_ready;
            din   = 16'(16'h0100 + sent);
            if (in_ready) sent++;
            cyc();
        end
        en_in = 1'b0;
        rdy2  = 1'b1;
        repeat (8) cyc();
        chk("t6_noloss", popped2, sent);
        chk("t6_ovf", ovf, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
